uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance among N_REQ byte producers, for example the CPU console and the hardware trace logger.
- Arbitration is round-robin between packets, with a packet lock so that multi-byte messages are never interleaved.
- Sequences the uart_tx handshake: issues the byte, waits for tx_ready to drop, then waits for it to return.
- Sits between the requesters and uart_tx; the serial line itself is untouched.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// arbiter's handshake sequencing states.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection. Scans from rr_ptr with wrap, or when a
// packet is in progress reports only whether the current owner still has data.
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             locked,
  input  logic [IDX_W-1:0] owner,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  // One spare bit so rr_ptr + offset cannot overflow before the explicit
  // modulo fold; this keeps non-power-of-2 sizes off the unused codes.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    if (locked) begin
      winner = owner;
      found  = req[owner];
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        sum = {1'b0, rr_ptr} + SUM_W'(i);
        if (sum >= SUM_W'(N_REQ)) begin
          sum = sum - SUM_W'(N_REQ);
        end
        if (!found && req[sum[IDX_W-1:0]]) begin
          found  = 1'b1;
          winner = sum[IDX_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte producers: round-robin between packets,
// packet lock against interleaving, and the tx_en / tx_ready handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]       tx_byte,
  output logic                         tx_en,
  input  logic                         tx_ready,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

  arb_state_e state, state_next;

  logic [IDX_W-1:0]       rr_ptr;
  logic                   locked;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   timeout_hit;
  logic [IDX_W-1:0]       winner;
  logic                   found;
  logic                   grant;
  logic [IDX_W-1:0]       ptr_after_grant;
  logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .locked (locked),
    .owner  (grant_id),
    .winner (winner),
    .found  (found)
  );

  assign cnt_inc         = cnt + 1'b1;
  assign timeout_hit     = (cnt_inc == CNT_W'(BUSY_TIMEOUT - 1));
  assign ptr_after_grant = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // req_ready is a same-cycle accept; gating on rst_n keeps it low the
  // instant reset asserts, even though state is already IDLE then.
  always_comb begin
    state_next = state;
    tx_en      = 1'b0;
    req_ready  = '0;
    grant      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_n && tx_ready && found) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_en      = 1'b1;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_next = ST_WAIT_DONE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The round-robin pointer only moves once a whole packet has gone out,
  // so a locked owner keeps its turn across every byte of its message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte     <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            tx_byte  <= req_bytes[winner];
            grant_id <= winner;
            locked   <= !req_last[winner];
          end
        end
        ST_ISSUE: begin
          cnt <= '0;
        end
        ST_WAIT_BUSY: begin
          if (tx_ready) begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
              timeout_err <= 1'b1;
              locked      <= 1'b0;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready && !locked) begin
            rr_ptr <= ptr_after_grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx peer that
// logs every byte it accepts; expected streams are written out by hand.
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 2;
  localparam int BUSY_TIMEOUT = 16;
  localparam int SHIFT_CYC    = 10;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic        tx_ready  = 1'b1;
  logic [1:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        tx_en;
  logic [0:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_byte     (tx_byte),
    .tx_en       (tx_en),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [7:0] rx_q [$];
  int         grant_log [$];
  logic [1:0] pend_pop = '0;

  int peer_mode = 0;  // 0 normal, 1 tx_ready stuck high, 2 stuck low
  int shift_cnt = 0;
  bit cap_pend  = 1'b0;

  int cyc          = 0;
  int ready_pulses = 0;
  int ten_count    = 0;
  int ready_cyc    = 0;
  int ten_cyc      = 0;
  int err_cyc      = -1;

  // Inputs change on the falling edge; the DUT is observed 2 ns later so
  // combinational accepts reflect the final inputs of that cycle.
  always begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      pend_pop  = '0;
      cap_pend  = 1'b0;
      shift_cnt = 0;
      tx_ready  = 1'b1;
    end else begin
      if (pend_pop[0] && q0.size() > 0) void'(q0.pop_front());
      if (pend_pop[1] && q1.size() > 0) void'(q1.pop_front());
      pend_pop = '0;
      case (peer_mode)
        1: tx_ready = 1'b1;
        2: tx_ready = 1'b0;
        default: begin
          if (shift_cnt > 0) begin
            shift_cnt--;
            if (shift_cnt == 0) tx_ready = 1'b1;
          end else if (cap_pend) begin
            tx_ready  = 1'b0;
            cap_pend  = 1'b0;
            shift_cnt = SHIFT_CYC;
          end else begin
            if (tx_en && tx_ready) begin
              rx_q.push_back(tx_byte);
              cap_pend = 1'b1;
            end
            tx_ready = 1'b1;
          end
        end
      endcase
    end
    req_valid[0] = (q0.size() > 0);
    req_valid[1] = (q1.size() > 0);
    if (q0.size() > 0) begin
      req_data[7:0] = q0[0][7:0];
      req_last[0]   = q0[0][8];
    end
    if (q1.size() > 0) begin
      req_data[15:8] = q1[0][7:0];
      req_last[1]    = q1[0][8];
    end
    #2;
    if (rst_n) begin
      if (req_ready != 2'b00) begin
        ready_pulses++;
        ready_cyc = cyc;
        grant_log.push_back(req_ready[1] ? 1 : 0);
        pend_pop = req_ready & req_valid;
      end
      if (tx_en) begin
        ten_count++;
        ten_cyc = cyc;
      end
      if (timeout_err && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int req, input logic [7:0] data, input bit last);
    if (req == 0) q0.push_back({last, data});
    else          q1.push_back({last, data});
  endtask

  task automatic clearLogs();
    rx_q.delete();
    grant_log.delete();
    ready_pulses = 0;
    ten_count    = 0;
    err_cyc      = -1;
  endtask

  function automatic logic [31:0] rxAt(input int i);
    if (i < rx_q.size()) return {24'd0, rx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] grantAt(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic waitDrain(input string tag);
    int stable = 0;
    for (int n = 0; n < 400 && stable < 3; n++) begin
      @(posedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && pend_pop == 2'b00 && !busy &&
          shift_cnt == 0 && !cap_pend)
        stable++;
      else
        stable = 0;
    end
    if (stable < 3) checkOutput({tag, "_drain"}, 32'd0, 32'd1);
  endtask

  task automatic waitGrant(input string tag, input int n);
    int k = 0;
    while (grant_log.size() < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (grant_log.size() < n) checkOutput({tag, "_grant_wait"}, 32'd0, 32'd1);
  endtask

  task automatic checkStream(input string tag, input int n,
                             input logic [7:0] exp_b [8], input int exp_g [8]);
    checkOutput({tag, "_rx_count"}, rx_q.size(), n);
    checkOutput({tag, "_grant_count"}, grant_log.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_rx%0d", tag, i), rxAt(i), {24'd0, exp_b[i]});
      checkOutput($sformatf("%s_gid%0d", tag, i), grantAt(i), exp_g[i]);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx_en", tx_en, 0);
    checkOutput("rst_tx_byte", tx_byte, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single byte from req0
    @(posedge clk);
    #1;
    clearLogs();
    applyStimulus(0, 8'hAB, 1'b1);
    waitDrain("t1");
    checkStream("t1", 1, '{8'hAB, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    checkOutput("t1_ready_pulses", ready_pulses, 1);
    checkOutput("t1_tx_en_pulses", ten_count, 1);
    checkOutput("t1_grant_to_tx_en", ten_cyc - ready_cyc, 1);
    checkOutput("t1_busy_after", busy, 0);

    // Single byte from req1; pointer returns to 0 afterwards
    clearLogs();
    applyStimulus(1, 8'h5A, 1'b1);
    waitDrain("t1b");
    checkStream("t1b", 1, '{8'h5A, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});
    checkOutput("t1b_grant_id", grant_id, 1);

    // Simultaneous single-byte packets alternate
    clearLogs();
    applyStimulus(0, 8'h11, 1'b1);
    applyStimulus(0, 8'h11, 1'b1);
    applyStimulus(1, 8'h22, 1'b1);
    applyStimulus(1, 8'h22, 1'b1);
    waitDrain("t2");
    checkStream("t2", 4, '{8'h11, 8'h22, 8'h11, 8'h22, 0, 0, 0, 0},
                '{0, 1, 0, 1, 0, 0, 0, 0});

    // One more req0 byte leaves the pointer at 1
    clearLogs();
    applyStimulus(0, 8'h77, 1'b1);
    waitDrain("t2b");
    checkStream("t2b", 1, '{8'h77, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Locked packet: req1 joins after the first byte and would win without the lock
    clearLogs();
    applyStimulus(0, 8'hAB, 1'b0);
    applyStimulus(0, 8'hFF, 1'b0);
    applyStimulus(0, 8'h00, 1'b0);
    applyStimulus(0, 8'h12, 1'b1);
    waitGrant("t3", 1);
    applyStimulus(1, 8'h55, 1'b1);
    waitDrain("t3");
    checkStream("t3", 5, '{8'hAB, 8'hFF, 8'h00, 8'h12, 8'h55, 0, 0, 0},
                '{0, 0, 0, 0, 1, 0, 0, 0});

    // Stall with tx_ready low
    clearLogs();
    peer_mode = 2;
    applyStimulus(0, 8'h3C, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("stall_req_ready", ready_pulses, 0);
    checkOutput("stall_tx_en", ten_count, 0);
    checkOutput("stall_busy", busy, 0);
    peer_mode = 0;
    waitDrain("stall_release");
    checkStream("stall_release", 1, '{8'h3C, 0, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0});

    // Timeout with tx_ready stuck high
    clearLogs();
    peer_mode = 1;
    applyStimulus(1, 8'h42, 1'b1);
    waitDrain("to");
    checkOutput("to_err", timeout_err, 1);
    checkOutput("to_latency", err_cyc - ten_cyc, 16);
    checkOutput("to_grants", grant_log.size(), 1);
    checkOutput("to_grant_id", grant_id, 1);
    checkOutput("to_rx_count", rx_q.size(), 0);
    checkOutput("to_busy", busy, 0);
    peer_mode = 0;
    clearLogs();
    applyStimulus(0, 8'h24, 1'b1);
    waitDrain("to_next");
    checkStream("to_next", 1, '{8'h24, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    checkOutput("to_sticky", timeout_err, 1);

    // Reset while in WAIT_DONE; pointer was 1 at that moment
    clearLogs();
    applyStimulus(0, 8'h96, 1'b1);
    for (int k = 0; k < 50 && shift_cnt == 0; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_shift_seen", (shift_cnt > 0), 1);
    @(posedge clk);
    #3;
    checkOutput("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_tx_en", tx_en, 0);
    checkOutput("mid_tx_byte", tx_byte, 0);
    checkOutput("mid_req_ready", req_ready, 0);
    checkOutput("mid_grant_id", grant_id, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clearLogs();
    applyStimulus(0, 8'hE1, 1'b1);
    applyStimulus(1, 8'hC3, 1'b1);
    waitDrain("post_rst");
    checkStream("post_rst", 2, '{8'hE1, 8'hC3, 0, 0, 0, 0, 0, 0},
                '{0, 1, 0, 0, 0, 0, 0, 0});
    checkOutput("post_rst_grant_id", grant_id, 1);
    checkOutput("post_rst_tx_byte", tx_byte, 8'hC3);
    checkOutput("post_rst_err", timeout_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
